tinker_exec_unit: RTL
=====================

// Module: tinker_exec_unit
// PURPOSE
//  Parametrised multi-cycle Tinker execute core: accepts one 32-bit instruction per valid/ready handshake.
//  Decodes the instruction, reads an internal register file, executes, then writes back.
//  Single-cycle logic/shift/add/mov ops; iterative (1 bit/cycle) unsigned mul and div.
//  Sits between the instruction fetch stage and the register-visible architectural state.
// PARAMETERS
//  DATA_W     64        register/ALU width (>=16)
//  NUM_REGS   32        architectural registers; power of two, <=32
//  STACK_INIT 64'h80000 reset value of r[NUM_REGS-1] (stack pointer); other regs reset to 0
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       core can accept (1 only in IDLE)
//  instr        in   32      op[31:27] rd[26:22] rs[21:17] rt[16:12] L[11:0]
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse: instruction retired
//  illegal      out  1       1-cycle pulse with done: bad opcode/reg index, no write
//  wb_en        out  1       1-cycle pulse with done when a register was written
//  wb_addr      out  5       register written
//  wb_data      out  DATA_W  value written
//  dbg_addr     in   5       debug read index (values >= NUM_REGS read 0)
//  dbg_data     out  DATA_W  combinational register read
// BEHAVIOUR
//  Reset: FSM=IDLE; regs cleared except r[NUM_REGS-1]=STACK_INIT; done/illegal/wb_en=0.
//   wb_addr/wb_data=0; iteration counter=0. Reset mid-op aborts it; no write occurs.
//  FSM: IDLE -(valid&ready)-> EXEC; EXEC -(mul/div)-> ITER else -> IDLE; ITER -(cnt==DATA_W-1)-> IDLE.
//  Accept edge: latch op, rd, L, and R[rs], R[rt], R[rd] (read-before-accept; no hazards possible).
//  Single-cycle op: register write at edge after accept (EXEC), done/wb_en high the following cycle.
//   Throughput is 1 instr / 2 cycles; instr_ready is high in that same done cycle.
//  mul/div: EXEC inits; DATA_W ITER edges; write on the last one (accept+1+DATA_W edges).
//  Opcodes (L zero-extended to DATA_W; all arithmetic wraps mod 2^DATA_W):
//   0x00 and rd=rs&rt | 0x01 or | 0x02 xor | 0x03 not rd=~rs
//   0x04 shftr rd=rs>>rt | 0x05 shftri rd=rd>>L | 0x06 shftl rd=rs<<rt | 0x07 shftli rd=rd<<L
//   Shift amount >= DATA_W gives 0 (logical shifts only).
//   0x11 mov rd=rs | 0x12 mov rd[11:0]=L, upper bits kept
//   0x18 add rd=rs+rt | 0x19 addi rd=rd+L | 0x1a sub rd=rs-rt | 0x1b subi rd=rd-L
//   0x1c mul rd=low DATA_W bits of rs*rt, shift-add, unsigned
//   0x1d div rd=rs/rt restoring, unsigned; rt==0 -> all ones, full latency, no illegal
//  Any other opcode, or rd/rs/rt >= NUM_REGS: EXEC->IDLE, no write, done=illegal=1, wb_en=0.
//  rd==rs/rt allowed (operands latched at accept). Write to r[NUM_REGS-1] is normal.
//  instr_valid while busy is ignored (ready=0); the offer must be held until accepted.
//  dbg_data reflects the register value after the write edge (same cycle done is high).
// TESTING
//  1 Reset -> dbg r31=0x80000, r0..r30=0, ready=1, done=0.
//  2 mov r1,L=0xABC; addi r1,L=4 -> r1=0xAC0, each done 2 cycles after accept, wb_addr=1.
//  3 r2=7,r3=6: mul r4,r2,r3 -> r4=42, done exactly DATA_W+2 cycles after accept; ready=0 meanwhile.
//  4 div r5,r2,r0(=0) -> r5=all ones; r5=100/7 -> 14; sub 0-1 -> 0xFFFF..FF (wrap).
//  5 shftli r1,L=64 -> 0; shftr by rt=3 of 0x80 -> 0x10; opcode 0x1f -> illegal+done, regs unchanged.
//  6 reset asserted mid-div -> IDLE next cycle, no wb_en, regs at reset values; back-to-back valid held high accepts in order.

Source files
------------

// File: rtl/tinker_exec_unit_if.sv
// Instruction handshake, writeback report and debug-read bundle for the Tinker execute core.
// The fetch side (master) offers instructions; the core (slave) retires them.
interface tinker_exec_unit_if #(
  parameter int DATA_W = 64
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              busy;
  logic              done;
  logic              illegal;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, dbg_addr,
    input  instr_ready, busy, done, illegal, wb_en, wb_addr, wb_data, dbg_data
  );

  modport slave (
    input  instr_valid, instr, dbg_addr,
    output instr_ready, busy, done, illegal, wb_en, wb_addr, wb_data, dbg_data
  );
endinterface

// File: rtl/tinker_exec_unit.sv
// Multi-cycle Tinker execute core: latch operands on accept, execute (single-cycle ALU or
// 1-bit/cycle mul/div), write back into the internal register file and report the retirement.
module tinker_exec_unit #(
  parameter int                DATA_W     = 64,
  parameter int                NUM_REGS   = 32,
  parameter logic [DATA_W-1:0] STACK_INIT = DATA_W'(64'h80000)
) (
  input  logic             clk,
  input  logic             reset,
  tinker_exec_unit_if.slave bus
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0]     LAST = CW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] DW_V = DATA_W'(DATA_W);
  localparam logic [4:0] OP_MUL = 5'h1c;
  localparam logic [4:0] OP_DIV = 5'h1d;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_ITER = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [4:0]        op_q, op_d, rd_q, rd_d;
  logic [11:0]       l_q, l_d;
  logic              bad_q, bad_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATA_W-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d, ill_q, ill_d, wb_en_q, wb_en_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic              we_s, ge_s;
  logic [DATA_W-1:0] wdata_s, res_s, acc_n_s, x_n_s, y_n_s, diff_s, lz_s;
  logic [DATA_W:0]   rem_sh_s;
  logic [4:0]        rs_s, rt_s, rdi_s;

  function automatic logic reg_ok(input logic [4:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
      5'h11, 5'h12, 5'h18, 5'h19, 5'h1a, 5'h1b, 5'h1c, 5'h1d: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Logical shifts saturate to zero once the amount reaches the datapath width.
  function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] amt);
    return (amt >= DW_V) ? '0 : (v >> amt);
  endfunction

  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] amt);
    return (amt >= DW_V) ? '0 : (v << amt);
  endfunction

  assign rdi_s = bus.instr[26:22];
  assign rs_s  = bus.instr[21:17];
  assign rt_s  = bus.instr[16:12];
  assign lz_s  = DATA_W'(l_q);

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.illegal     = ill_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.dbg_data    = reg_ok(bus.dbg_addr) ? rf_q[bus.dbg_addr[AW-1:0]] : '0;

  // Single-cycle ALU result from the operands captured at accept.
  always_comb begin
    res_s = '0;
    case (op_q)
      5'h00:   res_s = a_q & b_q;
      5'h01:   res_s = a_q | b_q;
      5'h02:   res_s = a_q ^ b_q;
      5'h03:   res_s = ~a_q;
      5'h04:   res_s = shr(a_q, b_q);
      5'h05:   res_s = shr(c_q, lz_s);
      5'h06:   res_s = shl(a_q, b_q);
      5'h07:   res_s = shl(c_q, lz_s);
      5'h11:   res_s = a_q;
      5'h12:   res_s = {c_q[DATA_W-1:12], l_q};
      5'h18:   res_s = a_q + b_q;
      5'h19:   res_s = c_q + lz_s;
      5'h1a:   res_s = a_q - b_q;
      5'h1b:   res_s = c_q - lz_s;
      default: res_s = '0;
    endcase
  end

  // One iteration step: shift-add multiply, or restoring divide with acc as remainder.
  always_comb begin
    rem_sh_s = {acc_q, x_q[DATA_W-1]};
    diff_s   = rem_sh_s[DATA_W-1:0] - y_q;
    ge_s     = (rem_sh_s >= {1'b0, y_q});
    if (op_q == OP_MUL) begin
      acc_n_s = y_q[0] ? (acc_q + x_q) : acc_q;
      x_n_s   = {x_q[DATA_W-2:0], 1'b0};
      y_n_s   = {1'b0, y_q[DATA_W-1:1]};
    end else begin
      acc_n_s = ge_s ? diff_s : rem_sh_s[DATA_W-1:0];
      x_n_s   = {x_q[DATA_W-2:0], ge_s};
      y_n_s   = y_q;
    end
  end

  // FSM next state, operand capture, iteration control and retirement report.
  always_comb begin
    state_d = state_q; op_d = op_q; rd_d = rd_q; l_d = l_q; bad_d = bad_q;
    a_d = a_q; b_d = b_q; c_d = c_q; acc_d = acc_q; x_d = x_q; y_d = y_q; cnt_d = cnt_q;
    done_d = 1'b0; ill_d = 1'b0; wb_en_d = 1'b0;
    wb_addr_d = wb_addr_q; wb_data_d = wb_data_q;
    we_s = 1'b0; wdata_s = res_s;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          op_d    = bus.instr[31:27];
          rd_d    = rdi_s;
          l_d     = bus.instr[11:0];
          bad_d   = !(reg_ok(rdi_s) && reg_ok(rs_s) && reg_ok(rt_s));
          a_d     = reg_ok(rs_s) ? rf_q[rs_s[AW-1:0]] : '0;
          b_d     = reg_ok(rt_s) ? rf_q[rt_s[AW-1:0]] : '0;
          c_d     = reg_ok(rdi_s) ? rf_q[rdi_s[AW-1:0]] : '0;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (bad_q || !op_legal(op_q)) begin
          done_d  = 1'b1;
          ill_d   = 1'b1;
          state_d = S_IDLE;
        end else if ((op_q == OP_MUL) || (op_q == OP_DIV)) begin
          acc_d   = '0;
          x_d     = a_q;
          y_d     = b_q;
          cnt_d   = '0;
          state_d = S_ITER;
        end else begin
          we_s    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        acc_d = acc_n_s;
        x_d   = x_n_s;
        y_d   = y_n_s;
        if (cnt_q == LAST) begin
          we_s    = 1'b1;
          wdata_s = (op_q == OP_MUL) ? acc_n_s : x_n_s;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_ITER;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (we_s) begin
      done_d    = 1'b1;
      wb_en_d   = 1'b1;
      wb_addr_d = rd_q;
      wb_data_d = wdata_s;
    end else begin
      wb_addr_d = wb_addr_q;
    end
  end

  // Control/datapath state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; op_q <= 5'd0; rd_q <= 5'd0; l_q <= 12'd0; bad_q <= 1'b0;
      a_q <= '0; b_q <= '0; c_q <= '0; acc_q <= '0; x_q <= '0; y_q <= '0; cnt_q <= '0;
      done_q <= 1'b0; ill_q <= 1'b0; wb_en_q <= 1'b0; wb_addr_q <= 5'd0; wb_data_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d; rd_q <= rd_d; l_q <= l_d; bad_q <= bad_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; acc_q <= acc_d; x_q <= x_d; y_q <= y_d; cnt_q <= cnt_d;
      done_q <= done_d; ill_q <= ill_d; wb_en_q <= wb_en_d; wb_addr_q <= wb_addr_d; wb_data_q <= wb_data_d;
    end
  end

  // Architectural register file; the top register holds the stack pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= (i == NUM_REGS - 1) ? STACK_INIT : '0;
      end
    end else if (we_s) begin
      rf_q[rd_q[AW-1:0]] <= wdata_s;
    end
  end
endmodule
